// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Sequential MIPS multiply/divide unit owning HI/LO; radix-2
//               shift-add multiply and restoring divide, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    input  logic                  cancel,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int         c_cnt_w = $clog2(DATA_WIDTH + 1);
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_calc  = 2'd1;
    localparam logic [1:0] c_fix   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  rt_zero_q, rt_zero_d;
    logic [DATA_WIDTH-1:0] opd_q, opd_d;
    logic [DATA_WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  div_zero_q, div_zero_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic                    w_signed;
    logic [DATA_WIDTH-1:0]   w_rs_abs;
    logic [DATA_WIDTH-1:0]   w_rt_abs;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH:0]     w_div_shift;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic                    w_div_ge;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quo_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;

    // Operand conditioning and one iteration of each datapath.
    always_comb begin
        w_signed    = ~op[0];
        w_rs_abs    = (w_signed && rs[DATA_WIDTH-1]) ? -rs : rs;
        w_rt_abs    = (w_signed && rt[DATA_WIDTH-1]) ? -rt : rt;
        w_mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
        w_div_shift = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, opd_q};
        // A set top bit of the shifted remainder already exceeds any divisor.
        w_div_ge    = w_div_shift[DATA_WIDTH] | ~w_div_diff[DATA_WIDTH];
        w_prod_fix  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        w_quo_fix   = neg_res_q ? -acc_lo_q : acc_lo_q;
        w_rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        rt_zero_d  = rt_zero_q;
        opd_d      = opd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_we ? wdata : hi_q;
        lo_d       = lo_we ? wdata : lo_q;

        case (state_q)
            c_idle: begin
                if (start) begin
                    state_d   = c_calc;
                    cnt_d     = c_cnt_w'(DATA_WIDTH);
                    is_div_d  = op[1];
                    neg_res_d = w_signed & (rs[DATA_WIDTH-1] ^ rt[DATA_WIDTH-1]);
                    neg_rem_d = w_signed & op[1] & rs[DATA_WIDTH-1];
                    rt_zero_d = (rt == '0);
                    acc_hi_d  = '0;
                    // Multiply shifts the multiplier out of acc_lo; divide
                    // shifts the dividend out of it and quotient bits in.
                    opd_d     = op[1] ? w_rt_abs : w_rs_abs;
                    acc_lo_d  = op[1] ? w_rs_abs : w_rt_abs;
                end
            end
            c_calc: begin
                if (cancel) begin
                    state_d = c_idle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                    if (cnt_q == c_cnt_w'(1)) begin
                        state_d = c_fix;
                    end
                    if (is_div_q) begin
                        acc_hi_d = w_div_ge ? w_div_diff[DATA_WIDTH-1:0]
                                            : w_div_shift[DATA_WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[DATA_WIDTH-2:0], w_div_ge};
                    end else begin
                        acc_hi_d = w_mul_sum[DATA_WIDTH:1];
                        acc_lo_d = {w_mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
                    end
                end
            end
            c_fix: begin
                state_d = c_idle;
                cnt_d   = '0;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // With rt=0 the remainder path reproduces the dividend.
                        hi_d       = w_rem_fix;
                        lo_d       = rt_zero_q ? '1 : w_quo_fix;
                        div_zero_d = rt_zero_q;
                    end else begin
                        hi_d = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                        lo_d = w_prod_fix[DATA_WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = c_idle;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != c_idle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_idle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rt_zero_q  <= 1'b0;
            opd_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            rt_zero_q  <= rt_zero_d;
            opd_q      <= opd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed and random checks of mul_div_unit against a 64-bit
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         cancel = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MIPS HI/LO semantics expressed with 64-bit integer arithmetic.
    task automatic model(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic dz, output logic [W-1:0] e_hi, output logic [W-1:0] e_lo);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0]     t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        t  = '0;
        case (m_op)
            2'd0: begin sp = sa * sb; t = sp; end
            2'd1: begin up = ua * ub; t = up; end
            default: begin
                if (b == '0) begin
                    dz = 1'b1;
                    t  = {a, 32'hFFFF_FFFF};
                end else if (m_op == 2'd2) begin
                    sp = sa % sb;
                    t[63:32] = sp[31:0];
                    sp = sa / sb;
                    t[31:0] = sp[31:0];
                end else begin
                    up = ua % ub;
                    t[63:32] = up[31:0];
                    up = ua / ub;
                    t[31:0] = up[31:0];
                end
            end
        endcase
        e_hi = t[63:32];
        e_lo = t[31:0];
    endtask

    task automatic issue(input logic [1:0] i_op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = i_op; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [1:0] c_op,
                                input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        logic         e_dz;
        logic [W-1:0] e_hi, e_lo;
        model(c_op, a, b, e_dz, e_hi, e_lo);
        chk({tag, ".latency"}, 64'(lat), 64'(W + 1));
        chk({tag, ".hi"}, 64'(hi), 64'(e_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(e_lo));
        chk({tag, ".div_zero"}, 64'(div_zero), 64'(e_dz));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 64'(done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] r_op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        issue(r_op, a, b);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        wait_done(0, lat);
        check_result(tag, r_op, a, b, lat);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int           lat;
        int           saw_done;
        logic [W-1:0] hold_hi, hold_lo;
        logic [1:0]   r_op;
        logic [W-1:0] ra, rb;

        repeat (2) @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.div_zero", 64'(div_zero), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        run_op("mulu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_neg", 2'd0, -32'sd7, 32'd3);
        run_op("div_neg", 2'd2, -32'sd7, 32'd2);
        run_op("divu_zero", 2'd3, 32'd100, 32'd0);
        run_op("div_zero_signed", 2'd2, -32'sd5, 32'd0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        // Second start while busy must be ignored.
        issue(2'd3, 32'd10, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd1; rs = 32'd7; rt = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat);
        check_result("ignore_start", 2'd3, 32'd10, 32'd3, lat - 1);
        chk("ignore_start.hi_direct", 64'(hi), 64'd1);

        // Start raised in the done cycle is accepted.
        issue(2'd3, 32'd10, 32'd3);
        wait_done(0, lat);
        start = 1'b1; op = 2'd1; rs = 32'd6; rt = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.busy", 64'(busy), 64'd1);
        wait_done(0, lat);
        check_result("b2b", 2'd1, 32'd6, 32'd7, lat);

        // MTHI / MTLO while idle.
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        chk("mthi", 64'(hi), 64'h1234);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'h5678);

        // Cancel at cycle 10.
        hold_hi = hi; hold_lo = lo;
        issue(2'd1, 32'd2, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel.busy", 64'(busy), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done++;
            @(negedge clk);
        end
        chk("cancel.no_done", 64'(saw_done), 64'd0);
        chk("cancel.hi", 64'(hi), 64'(hold_hi));
        chk("cancel.lo", 64'(lo), 64'(hold_lo));

        // Write during CALC is visible then overwritten; write at FIX edge loses.
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        lo_we = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        lo_we = 1'b0;
        chk("calc_write.lo", 64'(lo), 64'h5555);
        repeat (22) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("fix_wins.done", 64'(done), 64'd1);
        chk("fix_wins.hi", 64'(hi), 64'd0);
        chk("fix_wins.lo", 64'(lo), 64'd12);

        // Asynchronous reset mid-CALC.
        hi_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        hi_we = 1'b0;
        issue(2'd1, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.busy", 64'(busy), 64'd0);
        chk("async_rst.done", 64'(done), 64'd0);
        chk("async_rst.hi", 64'(hi), 64'd0);
        chk("async_rst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 2'd1, 32'd5, 32'd5);

        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom_range(0, 3));
            ra   = pick();
            rb   = pick();
            run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Sequential multiply/divide unit that owns the architectural HI/LO registers for the MIPS execute stage. The execute stage issues MUL/MULU/DIV/DIVU requests through a start/busy/done handshake. The unit computes the result over DATA_WIDTH iterations and writes HI/LO at completion. HI/LO are always visible on outputs for MFHI/MFLO and can be written directly by MTHI/MTLO.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; must be an even value of 8 or more.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only when busy=0.
- op  in  2  operation: 0=MUL (signed), 1=MULU, 2=DIV (signed), 3=DIVU.
- rs  in  DATA_WIDTH  multiplicand or dividend.
- rt  in  DATA_WIDTH  multiplier or divisor.
- cancel  in  1  abort the in-flight operation, for use on pipeline flush.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  DATA_WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO receive a result.
- div_zero  out  1  pulse alongside done when DIV/DIVU had rt=0.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

## Operation
- States:
  - IDLE: accepts start.
  - CALC: iterates; runs for DATA_WIDTH cycles.
  - FIX: applies sign correction, writes HI/LO, pulses done; always returns to IDLE.
- On accept in IDLE:
  - Latch op, |rs| and |rt| (absolute values for signed ops, raw values for unsigned ops), result signs, and rt==0.
  - Clear the accumulator.
  - Load iteration counter = DATA_WIDTH.
  - Go to CALC.
- MUL/MULU: radix-2 shift-add, one multiplier bit per cycle, into a 2·DATA_WIDTH product. Result: {hi,lo} = full product.
- DIV/DIVU: restoring division, one quotient bit per cycle. Results: lo = quotient, hi = remainder.
- Signed fix-up in FIX:
  - Product is negated if the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Signed overflow: (−2^(W−1)) / (−1) gives lo=0x8000_0000 and hi=0 (W=32).
- Divide by zero (DIV or DIVU): runs full latency; result hi=rs (original value), lo=all-ones; div_zero=1 with done.
- start while busy=1: ignored; no queuing.
- cancel while busy=1:
  - Next edge returns to IDLE.
  - HI/LO are unchanged; no done or div_zero pulse.
  - cancel in IDLE has no effect.
  - If start and cancel arrive together in IDLE, start is accepted.
- hi_we/lo_we:
  - Write wdata at the edge in any state.
  - If a write coincides with the FIX write, the FIX result wins for both registers.
  - A write during CALC is overwritten at completion.
- Widths: all internal sums are DATA_WIDTH+1 bits to keep the borrow/carry; outputs are exactly DATA_WIDTH.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset mid-operation discards the operation immediately.
- start high at rising edge N with busy=0:
  - busy=1 after edge N.
  - Edges N+1 … N+W perform the W iterations.
  - Edge N+W+1 (FIX) writes hi/lo, sets done=1 and busy=0.
  - Edge N+W+2 clears done.
- Latency from accept edge to result visible on hi/lo: W+1 cycles (33 for W=32). Throughput: one operation per W+2 cycles.
- Back-to-back: start may be high in the done cycle (busy=0) and is accepted at that edge.
- busy, done, div_zero, hi and lo are all registered; no combinational path from inputs to outputs.
- cancel sampled at edge N+k (1≤k≤W+1): busy=0 after that edge, and that edge performs no HI/LO update.

## Test plan
- MULU, rs=0xFFFF_FFFF, rt=0xFFFF_FFFF → after 33 cycles, hi=0xFFFF_FFFE, lo=0x0000_0001; done for exactly 1 cycle.
- MUL, rs=−7, rt=3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. DIV, rs=−7, rt=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1).
- DIVU, rs=100, rt=0 → hi=100, lo=0xFFFF_FFFF, div_zero=1 with done. DIV, rs=0x8000_0000, rt=−1 → lo=0x8000_0000, hi=0.
- Issue DIVU 10/3 and pulse start again at cycle 5 with different operands → second request ignored; hi=1, lo=3; start in the done cycle is accepted.
- MTHI 0x1234 while idle → hi=0x1234 next cycle. Start MULU 2×3, cancel at cycle 10 → busy=0, no done, hi/lo unchanged.
- Assert rst_n=0 mid-CALC → busy, done, hi and lo go to 0 asynchronously; after release, a new MULU 5×5 gives lo=25.
